// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Owner encoding doubles as the requester index into the packed port vectors.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        ACK     = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on contention the port not granted last wins.
module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic       grant_valid,
    output owner_t     grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = OWN_CPU;
        if (&req) begin
            grant_idx = (last == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else if (req[1]) begin
            grant_idx = OWN_DBG;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one single-port RAM,
// one transaction at a time, with registered RAM-side outputs.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
)(
    input  logic              clk_main,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] address_to_ram,
    output logic [DATA_W-1:0] data_to_ram,
    output logic              write_enable_to_ram,
    output logic              read_enable_to_ram,
    input  logic [DATA_W-1:0] data_from_ram,

    output logic              busy
);

    state_t state, state_nxt;
    owner_t owner_q, last_q, grant_idx;
    logic   grant_valid;
    logic   we_q;
    logic   sel;
    logic   [1:0] wait_cnt;
    logic   wait_done;

    logic [1:0]             req_vec;
    logic [1:0]             we_vec;
    logic [1:0][ADDR_W-1:0] addr_vec;
    logic [1:0][DATA_W-1:0] wdata_vec;

    assign req_vec   = {dbg_req, cpu_req};
    assign we_vec    = {dbg_we, cpu_we};
    assign addr_vec  = {dbg_addr, cpu_addr};
    assign wdata_vec = {dbg_wdata, cpu_wdata};
    assign sel       = grant_idx;

    assign wait_done = (wait_cnt == 2'(RD_LAT - 1));
    assign busy      = (state != IDLE);

    arb_rr2 u_rr (
        .req         (req_vec),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = we_q ? ACK : WAIT_RD;
            WAIT_RD: if (wait_done) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM controls are loaded on the grant edge so they are valid for the
    // whole ACCESS cycle, then the enables drop while address/data hold.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            owner_q             <= OWN_CPU;
            last_q              <= OWN_DBG;
            we_q                <= 1'b0;
            wait_cnt            <= '0;
            address_to_ram      <= '0;
            data_to_ram         <= '0;
            write_enable_to_ram <= 1'b0;
            read_enable_to_ram  <= 1'b0;
            cpu_ack             <= 1'b0;
            dbg_ack             <= 1'b0;
            cpu_rdata           <= '0;
            dbg_rdata           <= '0;
        end else begin
            write_enable_to_ram <= 1'b0;
            read_enable_to_ram  <= 1'b0;
            cpu_ack <= (state_nxt == ACK) && (owner_q == OWN_CPU);
            dbg_ack <= (state_nxt == ACK) && (owner_q == OWN_DBG);
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q             <= grant_idx;
                        we_q                <= we_vec[sel];
                        address_to_ram      <= addr_vec[sel];
                        write_enable_to_ram <= we_vec[sel];
                        read_enable_to_ram  <= !we_vec[sel];
                        if (we_vec[sel]) data_to_ram <= wdata_vec[sel];
                    end
                end
                ACCESS: wait_cnt <= '0;
                WAIT_RD: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_done) begin
                        if (owner_q == OWN_CPU) cpu_rdata <= data_from_ram;
                        else                    dbg_rdata <= data_from_ram;
                    end
                end
                ACK: last_q <= owner_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table of single-port transactions
// plus hand sequences for contention, mid-flight input changes and reset.
module tb_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int RL = 1;

    logic          clk_main = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] address_to_ram;
    logic [DW-1:0] data_to_ram;
    logic          write_enable_to_ram, read_enable_to_ram;
    logic [DW-1:0] data_from_ram;
    logic          busy;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk_main(clk_main), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .address_to_ram(address_to_ram), .data_to_ram(data_to_ram),
        .write_enable_to_ram(write_enable_to_ram), .read_enable_to_ram(read_enable_to_ram),
        .data_from_ram(data_from_ram), .busy(busy)
    );

    always #5 clk_main = ~clk_main;

    // RAM model: read data appears RL cycles after the enable cycle
    logic [DW-1:0] mem [64];
    logic [DW-1:0] rd_pipe [RL];
    assign data_from_ram = rd_pipe[RL-1];

    always @(posedge clk_main) begin
        if (write_enable_to_ram) mem[address_to_ram] <= data_to_ram;
        if (read_enable_to_ram) rd_pipe[0] <= mem[address_to_ram];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    int n_chk = 0;
    int n_fail = 0;
    int overlap = 0;

    always @(negedge clk_main) if (write_enable_to_ram && read_enable_to_ram) overlap++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, " dbg_ack"}, 32'(dbg_ack), 32'd0);
        check({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, " dbg_rdata"}, 32'(dbg_rdata), 32'd0);
        check({tag, " addr"}, 32'(address_to_ram), 32'd0);
        check({tag, " data"}, 32'(data_to_ram), 32'd0);
        check({tag, " we"}, 32'(write_enable_to_ram), 32'd0);
        check({tag, " re"}, 32'(read_enable_to_ram), 32'd0);
    endtask

    typedef struct {
        bit            dbg;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vt[8];

    task automatic run_txn(input vec_t v, output int lat, output logic [DW-1:0] rd,
                           output int n_we, output int n_re, output logic [AW-1:0] s_addr,
                           output logic [DW-1:0] s_data, output int other_ack);
        lat = 0; rd = '0; n_we = 0; n_re = 0; s_addr = '0; s_data = '0; other_ack = 0;
        @(negedge clk_main);
        if (v.dbg) begin
            dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_main);
            if (write_enable_to_ram) begin n_we++; s_addr = address_to_ram; s_data = data_to_ram; end
            if (read_enable_to_ram) begin n_re++; s_addr = address_to_ram; end
            if (v.dbg ? cpu_ack : dbg_ack) other_ack++;
            if (v.dbg ? dbg_ack : cpu_ack) begin
                lat = c;
                rd = v.dbg ? dbg_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    initial begin
        int            lat, n_we, n_re, other, nack, cyc;
        logic [DW-1:0] rd, s_data;
        logic [AW-1:0] s_addr;
        bit            order [4];
        bit            got_cpu;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[3] = 16'h8106;
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;

        //          dbg we  addr   wdata     lat rdata (of that port at ack)
        vt[0] = '{1'b0, 1'b1, 6'd6,  16'h0011, 2, 16'h0000};
        vt[1] = '{1'b1, 1'b0, 6'd3,  16'h0000, 3, 16'h8106};
        vt[2] = '{1'b0, 1'b0, 6'd6,  16'h0000, 3, 16'h0011};
        vt[3] = '{1'b1, 1'b1, 6'h3F, 16'hBEEF, 2, 16'h8106};
        vt[4] = '{1'b1, 1'b0, 6'h3F, 16'h0000, 3, 16'hBEEF};
        vt[5] = '{1'b0, 1'b1, 6'd0,  16'hFFFF, 2, 16'h0011};
        vt[6] = '{1'b0, 1'b0, 6'd0,  16'h0000, 3, 16'hFFFF};
        vt[7] = '{1'b0, 1'b1, 6'd6,  16'h0AAA, 2, 16'hFFFF};

        repeat (3) @(negedge clk_main);
        check_reset_outputs("por");
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i], lat, rd, n_we, n_re, s_addr, s_data, other);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("v%0d rdata", i), 32'(rd), 32'(vt[i].rdata));
            check($sformatf("v%0d we cycles", i), 32'(n_we), vt[i].we ? 32'd1 : 32'd0);
            check($sformatf("v%0d re cycles", i), 32'(n_re), vt[i].we ? 32'd0 : 32'd1);
            check($sformatf("v%0d ram addr", i), 32'(s_addr), 32'(vt[i].addr));
            if (vt[i].we) check($sformatf("v%0d ram data", i), 32'(s_data), 32'(vt[i].wdata));
            check($sformatf("v%0d other ack", i), 32'(other), 32'd0);
        end

        // Contention: reset restores CPU priority, then strict alternation
        @(negedge clk_main);
        reset = 1'b0;
        #1 check_reset_outputs("idle rst");
        @(negedge clk_main);
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd1; cpu_wdata = 16'h0101;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd2; dbg_wdata = 16'h0202;
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(negedge clk_main);
            if (cpu_ack && dbg_ack) check("rr dual ack", 32'd1, 32'd0);
            if (cpu_ack || dbg_ack) begin
                order[nack] = dbg_ack;
                nack++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("rr ack count", 32'(nack), 32'd4);
        check("rr order 0", 32'(order[0]), 32'd0);
        check("rr order 1", 32'(order[1]), 32'd1);
        check("rr order 2", 32'(order[2]), 32'd0);
        check("rr order 3", 32'(order[3]), 32'd1);
        check("rr mem[1]", 32'(mem[1]), 32'h0101);
        check("rr mem[2]", 32'(mem[2]), 32'h0202);

        // Inputs change and req drops right after the grant edge
        @(negedge clk_main);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd6; cpu_wdata = 16'h1234;
        @(posedge clk_main);
        #1;
        cpu_req = 1'b0; cpu_addr = 6'h3F; cpu_wdata = 16'h0000;
        @(negedge clk_main);
        check("mid ram addr", 32'(address_to_ram), 32'd6);
        check("mid ram data", 32'(data_to_ram), 32'h1234);
        check("mid we", 32'(write_enable_to_ram), 32'd1);
        @(negedge clk_main);
        check("mid cpu_ack", 32'(cpu_ack), 32'd1);
        check("mid busy at ack", 32'(busy), 32'd1);
        @(negedge clk_main);
        check("mid ack one cycle", 32'(cpu_ack), 32'd0);
        check("mid idle", 32'(busy), 32'd0);

        // Reset during WAIT_RD aborts the read; CPU then wins a tie
        @(negedge clk_main);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd3;
        @(posedge clk_main);
        @(posedge clk_main);
        #2;
        check("wait_rd busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1 check_reset_outputs("async rst");
        dbg_req = 1'b0;
        nack = 0;
        repeat (3) begin
            @(negedge clk_main);
            if (cpu_ack || dbg_ack) nack++;
        end
        check("abort no ack", 32'(nack), 32'd0);
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd6;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = 16'h0909;
        @(negedge clk_main);
        check("post rst re", 32'(read_enable_to_ram), 32'd1);
        check("post rst addr", 32'(address_to_ram), 32'd6);
        got_cpu = 1'b0;
        cyc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_main);
            if (cpu_ack || dbg_ack) begin
                got_cpu = cpu_ack && !dbg_ack;
                cyc = c + 1;
                break;
            end
        end
        check("post rst winner cpu", 32'(got_cpu), 32'd1);
        check("post rst latency", 32'(cyc), 32'd2);
        check("post rst cpu_rdata", 32'(cpu_rdata), 32'h1234);
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) @(negedge clk_main);

        check("enable overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6: RAM word-address width.
REQ-002 Parameter DATA_W, default 16: RAM data width.
REQ-003 Parameter RD_LAT, default 1, legal range 1..4: RAM read latency, in cycles after the ram_re cycle.
REQ-004 The clock and reset ports SHALL be as follows, and the block SHALL use this one clock only:
- clk_main  in  1  single clock.
- reset  in  1  asynchronous, active-low.
REQ-005 CPU requester port SHALL be:
- cpu_req  in  1  request, held until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack = 1.
REQ-006 The debug/loader requester port SHALL mirror REQ-005 with prefix dbg_: dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata.
REQ-007 RAM-side port SHALL be:
- address_to_ram  out  ADDR_W
- data_to_ram  out  DATA_W
- write_enable_to_ram  out  1
- read_enable_to_ram  out  1
- data_from_ram  in  DATA_W
REQ-008 Status output busy  out  1: high in every state except IDLE.

Function
REQ-009 FSM states: IDLE, ACCESS, WAIT_RD, ACK; one transaction at a time.
REQ-010 IDLE, no req: remain in IDLE.
REQ-011 IDLE, req present: choose the winner, latch the winner's we/addr/wdata into internal registers, record the owner, and go to ACCESS next cycle.
REQ-012 Single requester: that requester wins.
REQ-013 Both requesting: the port not granted last wins (round-robin).
REQ-014 After reset, the round-robin pointer SHALL favour CPU.
REQ-015 ACCESS lasts exactly 1 cycle:
- address_to_ram = latched address throughout.
- Write: write_enable_to_ram = 1 and data_to_ram = latched wdata; next state ACK.
- Read: read_enable_to_ram = 1; next state WAIT_RD.
REQ-016 WAIT_RD lasts RD_LAT cycles; data_from_ram SHALL be captured into the owner's rdata register at the end of the last one; next state ACK.
REQ-017 ACK lasts 1 cycle: only the owner's ack = 1; next state IDLE. The pointer updates to the owner.
REQ-018 Latency, req-seen cycle to ack cycle: write 2 cycles; read 2 + RD_LAT cycles.
REQ-019 write_enable_to_ram and read_enable_to_ram SHALL never both be 1, and SHALL be 0 outside ACCESS.
REQ-020 address_to_ram and data_to_ram SHALL hold their last values outside ACCESS.
REQ-021 Requester inputs changing after the grant SHALL NOT affect the transaction in flight.
REQ-022 Req dropped mid-transaction: the transaction completes and ack still pulses.
REQ-023 Req still high in the cycle after ack: treated as a new request in IDLE, subject to REQ-013. Back-to-back with both ports requesting SHALL alternate CPU, DBG, CPU, and so on.
REQ-024 rdata registers hold their value until the next read by the same port; a write SHALL NOT modify rdata.
REQ-025 Addresses span 0..2^ADDR_W-1 and pass through unmodified (no wrap or offset).

Reset
REQ-026 reset = 0 SHALL immediately, asynchronously, force:
- state = IDLE.
- pointer = favour CPU.
- all outputs = 0: acks, rdata, address_to_ram, data_to_ram, write_enable_to_ram, read_enable_to_ram, busy.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack. After release, requesters must re-issue.
REQ-028 On reset release, the first req SHALL be evaluated on the first rising clk_main edge.

Structure
REQ-029 Shared package ram_arb_pkg SHALL hold:
- state enum (IDLE, ACCESS, WAIT_RD, ACK).
- owner encoding (OWN_CPU = 0, OWN_DBG = 1).
- default ADDR_W, DATA_W, RD_LAT.
REQ-030 One sub-module, arb_rr2: 2-way round-robin picker. Inputs: req[1:0], last owner. Outputs: grant_valid, grant_idx. Purely combinational.
REQ-031 RAM-side outputs SHALL be driven directly from registers.

Verification
REQ-032 CPU write only: cpu_req = 1, we = 1, addr = 6, wdata = 0x0011 -> one ACCESS cycle with address_to_ram = 6, data_to_ram = 0x0011, write_enable_to_ram = 1; cpu_ack exactly 2 cycles after req seen.
REQ-033 DBG read, RD_LAT = 1: addr = 3, model returns 0x8106 -> read_enable_to_ram 1 cycle; dbg_ack 3 cycles after req with dbg_rdata = 0x8106; cpu_ack stays 0.
REQ-034 Both req held continuously, 4 transactions -> grant order CPU, DBG, CPU, DBG; no overlapping ram enables.
REQ-035 cpu_addr changed from 6 to 0x3F and cpu_req dropped during ACCESS -> RAM still sees address 6; cpu_ack still pulses.
REQ-036 reset = 0 during WAIT_RD -> all outputs 0 immediately; no ack; after release, a DBG request arriving at the same time as a CPU request loses to CPU.
